// File: rtl/demux1to11_dispatch.sv
// One-to-N word dispatcher: each accepted word lands in the holding register of its
// one-hot selected channel and is held there until the sink acks it. Illegal selects are dropped and counted.
module demux1to11_dispatch #(
    parameter int WIDTH = 40,
    parameter int N     = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic [N-1:0]       in_sel,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ack,
    output logic               err_sel,
    output logic [15:0]        drop_cnt
);

    logic         sel_legal;
    logic         slot_busy;
    logic         accept;
    logic [N-1:0] load;
    logic         drop;

    always_comb begin
        sel_legal = (in_sel != '0) && ((in_sel & (in_sel - N'(1))) == '0);
        // An occupied slot that is being acked this cycle is treated as free.
        slot_busy = |(in_sel & out_valid & ~out_ack);
        in_ready  = !rst && (!sel_legal || !slot_busy);
        accept    = in_valid && in_ready;
        load      = (accept && sel_legal) ? in_sel : '0;
        drop      = accept && !sel_legal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= '0;
            err_sel   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                // Load takes priority over a same-cycle ack so streaming into one channel never loses a word.
                if (load[i]) begin
                    out_data[i*WIDTH +: WIDTH] <= in_data;
                    out_valid[i]               <= 1'b1;
                end else if (out_ack[i] && out_valid[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            err_sel <= drop;
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/demux1to11_dispatch.md
# demux1to11_dispatch

Routes a single 40-bit data stream to one of N downstream sinks, which are the consumers of the 11-source selection path. Each word arrives with a one-hot destination select and is captured into a per-channel holding register. That register presents the word with a valid flag until the sink acknowledges it. Upstream backpressure applies only when the addressed slot is still occupied. Words with an illegal select are dropped, flagged and counted.

## Interface
- WIDTH, 40, data word width
- N, 11, number of output channels; in_sel is N bits one-hot
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  upstream data word
- in_valid  input  1  upstream word present
- in_sel  input  N  one-hot destination; bit i selects channel i
- in_ready  output  1  combinational; transfer occurs when in_valid && in_ready
- out_data  output  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH], registered
- out_valid  output  N  channel i holds an unconsumed word, registered
- out_ack  input  N  sink i consumes word; effective only when out_valid[i]=1
- err_sel  output  1  registered one-cycle pulse per dropped word
- drop_cnt  output  16  count of dropped words, saturating at 16'hFFFF

## Operation
- Reset state: out_data=0, out_valid=0, err_sel=0, drop_cnt=0. During rst, in_ready=0 and no transfer occurs.
- Legal select: in_sel has exactly one bit set.
- in_ready for a legal select: 1 when !(out_valid[i] && !out_ack[i]) for the selected i. The slot is therefore writable when it is empty or is being acknowledged in the same cycle.
- in_ready for an illegal select (zero or multi-hot): 1. The word is always accepted and dropped.
- Accept on legal select i: out_data[i] <= in_data and out_valid[i] <= 1. No other channel changes.
- Accept on illegal select:
  - No channel changes.
  - err_sel <= 1 for the next cycle only.
  - drop_cnt increments, holding at 16'hFFFF.
- On out_ack[i] && out_valid[i] with no same-cycle load of i: out_valid[i] <= 0. out_data[i] holds its last value.
- On simultaneous ack and load of channel i: the load wins. out_valid[i] stays 1 and out_data[i] takes the new word. No word is lost or duplicated.
- out_ack[i] while out_valid[i]=0 is ignored.
- Channels are independent. Acks on several channels in one cycle are all honoured.
- in_valid=0 leaves in_sel and in_data don't-care. in_ready still reflects in_sel, but no state changes.
- A reset in mid-operation discards every held word, clears every valid, and zeroes drop_cnt on the next edge.

## Timing
- Accept-to-out_valid latency is 1 cycle: the word is accepted at edge k, and out_valid[i]/out_data[i] are visible after edge k.
- Ack-to-clear is 1 cycle.
- Throughput:
  - One word per cycle when consecutive words target different channels.
  - One word per cycle into the same channel when its sink acks every cycle, using the same-cycle ack/load path.
- Stall: if channel i is occupied and out_ack[i]=0, in_ready=0 for that select. Upstream must hold in_valid, in_data and in_sel stable until in_ready=1.
- err_sel rises 1 cycle after the illegal accept and lasts exactly 1 cycle per dropped word. Back-to-back illegal words keep it high continuously.
- in_ready has a combinational path from in_sel, out_ack and rst. There is no combinational path from in_data to any output.

## Test plan
- Reset, then in_valid=1, in_sel=11'b00000000100, in_data=40'h12_3456_789A, all out_ack=0 -> one cycle later out_valid=11'b00000000100 and channel 2 data=40'h12_3456_789A. All other channel data stays 0.
- With channel 2 occupied and not acked, present a second word to channel 2 -> in_ready=0 and the held data is unchanged. Assert out_ack[2] -> in_ready=1 in the same cycle. Next cycle channel 2 holds the new word and out_valid[2]=1.
- Stream 11 words in 11 cycles to channels 0..10 with data=channel index, no acks -> all out_valid=11'h7FF, each channel data equals its index, and in_ready stays 1 throughout.
- in_sel=0, then in_sel=11'b00000000011, each with in_valid=1 -> both accepted, out_valid unchanged, err_sel high for the 2 following cycles, drop_cnt=2. Preload drop_cnt to 16'hFFFE and drop 3 words -> drop_cnt=16'hFFFF.
- Channels 0, 5 and 10 are valid. Ack all three in one cycle -> all three clear. Ack channel 3 while it is empty -> no state change.
- Assert rst for one cycle with channels valid and upstream stalled -> in_ready=0 during rst. Afterwards all outputs return to reset values, and the next legal word is accepted normally.
